// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control FSM for the lime datapath.
// Decodes {Func, Opc} into datapath strobes with a memory-wait handshake, a global
// stall, and a retire pulse/counter. Optional trap handling (illegal decode and
// memory-wait timeout into an absorbing TRAP state) is enabled by defining CTRL_TRAP_EN.
module mc_control_fsm #(
    parameter int unsigned FUNC_W  = 4,
    parameter int unsigned OPC_W   = 3,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned TMO_W   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic [FUNC_W-1:0]  Func,
    input  logic [OPC_W-1:0]   Opc,
    input  logic               Stall,
    input  logic               MemReady,
    output logic               Branch,
    output logic               IoD,
    output logic               IRWrite,
    output logic               Mem2Reg,
    output logic               MemR,
    output logic               MemW,
    output logic               PCSrc,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         BranchType,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [3:0]         State,
    output logic               Retire,
    output logic [CNT_W-1:0]   RetireCnt,
    output logic               Illegal,
    output logic               MemTimeout
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_RTYPE    = 4'd2,
        S_RITYPE   = 4'd3,
        S_RTYPEEND = 4'd4,
        S_LW1      = 4'd5,
        S_LW2      = 4'd6,
        S_SW       = 4'd7,
        S_JALR     = 4'd8,
        S_BRANCH   = 4'd9,
        S_BRANCH2  = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [TMO_W-1:0] WAIT_MAX = '1;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic             tmo_q, tmo_d;
    logic             retire_c;
    logic             mem_wait_c;
    logic             illegal_c;
    logic [3:0]       func_lo;
    logic [2:0]       opc_lo;
    logic             upper_nz;
    logic [3:0]       alu_code;

    assign func_lo  = Func[3:0];
    assign opc_lo   = Opc[2:0];
    // Any nonzero bit above the architected fields makes the instruction illegal.
    assign upper_nz = ((Func >> 4) != '0) || ((Opc >> 3) != '0);

    // Map the func field onto the 4-bit ALU operation code.
    function automatic logic [3:0] alu_map(input logic [3:0] f);
        logic [3:0] r;
        if (f <= 4'd8) begin
            r = f;
        end else if (f == 4'd9 || f == 4'd10) begin
            r = 4'd9;
        end else if (f == 4'd12) begin
            r = 4'd12;
        end else begin
            r = 4'hF;
        end
        return r;
    endfunction

    // Next-state, wait counter, retire counter and fault flags.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cnt_d      = cnt_q;
        ill_d      = ill_q;
        tmo_d      = tmo_q;
        retire_c   = 1'b0;
        mem_wait_c = 1'b0;
        illegal_c  = 1'b0;
        if (!Stall) begin
            case (state_q)
                S_FETCH: begin
                    if (MemReady) state_d = S_DECODE;
                    else          mem_wait_c = 1'b1;
                end
                S_DECODE: begin
                    if (upper_nz) begin
                        illegal_c = 1'b1;
                    end else begin
                        case (opc_lo)
                            3'd0: state_d = S_RTYPE;
                            3'd1: begin
                                if (func_lo == 4'd11)      state_d = S_JALR;
                                else if (func_lo >= 4'd12) state_d = S_BRANCH;
                                else                       state_d = S_RITYPE;
                            end
                            3'd2: state_d = S_RITYPE;
                            3'd3: begin
                                state_d  = S_FETCH;
                                retire_c = 1'b1;
                            end
                            3'd4:    state_d = S_JAL;
                            default: illegal_c = 1'b1;
                        endcase
                    end
                end
                S_RTYPE: state_d = S_RTYPEEND;
                S_RITYPE: begin
                    if (func_lo == 4'd9)       state_d = S_LW1;
                    else if (func_lo == 4'd10) state_d = S_SW;
                    else                       state_d = S_RTYPEEND;
                end
                S_LW1: begin
                    if (MemReady) state_d = S_LW2;
                    else          mem_wait_c = 1'b1;
                end
                S_SW: begin
                    if (MemReady) begin
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end else begin
                        mem_wait_c = 1'b1;
                    end
                end
                S_RTYPEEND, S_LW2, S_JAL, S_JALR, S_BRANCH2: begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end
                S_BRANCH: state_d = S_BRANCH2;
                S_TRAP:   state_d = S_TRAP;
                default:  state_d = S_FETCH;
            endcase
`ifdef CTRL_TRAP_EN
            if (illegal_c) begin
                state_d = S_TRAP;
                ill_d   = 1'b1;
            end
            // The held cycle that brings the counter to its maximum ends the wait.
            if (mem_wait_c && (wait_q == WAIT_MAX - TMO_W'(1))) begin
                state_d = S_TRAP;
                tmo_d   = 1'b1;
            end
`else
            if (illegal_c) state_d = S_FETCH;
`endif
            if (state_d != state_q) begin
                wait_d = '0;
            end else if (mem_wait_c && (wait_q != WAIT_MAX)) begin
                wait_d = wait_q + TMO_W'(1);
            end
            if (retire_c) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            tmo_q   <= tmo_d;
        end
    end

    // Datapath strobes decoded from the current state, then stall/reset gating.
    always_comb begin
        Branch     = 1'b0;
        IoD        = 1'b0;
        IRWrite    = 1'b0;
        Mem2Reg    = 1'b0;
        MemR       = 1'b0;
        MemW       = 1'b0;
        PCSrc      = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        BranchType = 2'd0;
        alu_code   = 4'hF;
        case (state_q)
            S_FETCH: begin
                MemR     = 1'b1;
                ALUSrcB  = 2'd1;
                alu_code = 4'd0;
                IRWrite  = MemReady;
                PCWrite  = MemReady;
            end
            S_RTYPE: begin
                alu_code = alu_map(func_lo);
                ALUSrcA  = 2'd2;
            end
            S_RITYPE: begin
                alu_code = alu_map(func_lo);
                ALUSrcA  = 2'd2;
                ALUSrcB  = 2'd2;
            end
            S_RTYPEEND: RegWrite = 1'b1;
            S_LW1: begin
                IoD  = 1'b1;
                MemR = 1'b1;
            end
            S_LW2: begin
                RegWrite = 1'b1;
                Mem2Reg  = 1'b1;
            end
            S_SW: begin
                IoD    = 1'b1;
                MemW   = 1'b1;
                Branch = 1'b1;
            end
            S_JALR: begin
                alu_code = 4'd7;
                ALUSrcA  = 2'd3;
                ALUSrcB  = 2'd1;
                RegWrite = 1'b1;
            end
            S_JAL: begin
                alu_code = 4'd7;
                ALUSrcA  = 2'd3;
                ALUSrcB  = 2'd1;
                PCWrite  = 1'b1;
            end
            S_BRANCH: begin
                alu_code   = 4'd9;
                ALUSrcB    = 2'd2;
                Branch     = 1'b1;
                BranchType = func_lo[1:0];
            end
            S_BRANCH2: begin
                alu_code   = 4'd1;
                ALUSrcA    = 2'd2;
                Branch     = 1'b1;
                BranchType = func_lo[1:0];
                PCSrc      = 1'b1;
                PCWrite    = 1'b1;
            end
            default: ;
        endcase
        if (Stall) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemW     = 1'b0;
        end
        if (!Reset_n) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemW     = 1'b0;
            MemR     = 1'b0;
        end
        ALUOp = ALUOP_W'(alu_code);
    end

    assign State      = state_q;
    assign Retire     = retire_c & Reset_n;
    assign RetireCnt  = cnt_q;
    assign Illegal    = ill_q;
    assign MemTimeout = tmo_q;

endmodule
